tinker_mem_unit: RTL



---
 rtl/tinker_mem_pkg.sv | 51 +++++
 rtl/tinker_mem_array.sv | 43 ++++
 rtl/tinker_mem_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types and helpers for the Tinker unified memory unit.
//   size_e  : data access size encoding (1/2/4/8 bytes)
//   state_e : transaction FSM states
//   grant_e : which port owns (or last owned) the memory
//   bytes_of: byte count of an access size
//   be_of   : low-aligned byte-enable mask of an access size
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  function automatic logic [3:0] bytes_of(input size_e size);
    logic [3:0] n;
    case (size)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      SZ_D:    n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] be_of(input size_e size);
    logic [7:0] be;
    case (size)
      SZ_B:    be = 8'h01;
      SZ_H:    be = 8'h03;
      SZ_W:    be = 8'h0F;
      SZ_D:    be = 8'hFF;
      default: be = 8'h01;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/tinker_mem_array.sv
// Byte-addressed storage for the Tinker memory unit.
// Contents are intentionally not reset.
//   clk      : clock
//   raddr_i  : start byte address of an 8-byte combinational read
//   rdata_o  : bytes raddr_i..raddr_i+7, little-endian (index wraps)
//   we_i     : write enable
//   waddr_i  : start byte address of the write
//   wbe_i    : byte enables relative to waddr_i
//   wdata_i  : write data, byte i goes to waddr_i+i
module tinker_mem_array #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [63:0]       rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wbe_i,
  input  logic [63:0]       wdata_i
);

  logic [7:0] mem_q [2**ADDR_W];

  // Combinational 8-byte little-endian read window.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < 8; i++) begin
      rdata_o[8*i +: 8] = mem_q[raddr_i + ADDR_W'(i)];
    end
  end

  // Byte-enable synchronous write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (wbe_i[i]) begin
          mem_q[waddr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/tinker_mem_unit.sv
// Unified instruction/data memory for the multi-cycle Tinker core.
// Two valid/ready request ports share one byte array; round-robin
// arbitration, one transaction in flight, fixed-latency responses.
//   clk, reset                       : clock, async active-high reset
//   if_req_valid/if_req_ready        : fetch request handshake
//   if_addr                          : fetch byte address (4-byte read)
//   if_rsp_valid/if_rdata/if_err     : fetch response pulse, data, range error
//   d_req_valid/d_req_ready          : data request handshake
//   d_we/d_size/d_addr/d_wdata       : store flag, size code, address, store data
//   d_rsp_valid/d_rdata/d_err        : data response pulse, load data, range error
module tinker_mem_unit
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 64,
  parameter int INSN_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [INSN_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err
);

  localparam logic [15:0] WAIT_LAST = 16'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  grant_e            last_q, last_d;

  logic              if_ready_s, d_ready_s;
  logic              acc_if_s, acc_d_s, accept_s;
  logic [ADDR_W-1:0] rd_addr_s;
  size_e             size_s;
  logic [7:0]        be_s;
  logic [ADDR_W:0]   end_s;
  logic              err_s;
  logic [63:0]       arr_rdata_s;
  logic [63:0]       fresh_data_s;
  logic              arr_we_s;

  logic [63:0]       cap_data_q;
  logic              cap_err_q;
  grant_e            cap_port_q;

  logic              enter_resp_s;
  grant_e            rsp_port_s;
  logic [63:0]       rsp_data_s;
  logic              rsp_err_s;

  logic              if_rsp_valid_q, d_rsp_valid_q, if_err_q, d_err_q;
  logic [INSN_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Round-robin arbiter: only in IDLE; on a tie the port not granted last wins.
  always_comb begin
    if_ready_s = 1'b0;
    d_ready_s  = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_valid && d_req_valid) begin
        if (last_q == GNT_IF) begin
          d_ready_s = 1'b1;
        end else begin
          if_ready_s = 1'b1;
        end
      end else if (d_req_valid) begin
        d_ready_s = 1'b1;
      end else if (if_req_valid) begin
        if_ready_s = 1'b1;
      end else begin
        if_ready_s = 1'b0;
        d_ready_s  = 1'b0;
      end
    end else begin
      if_ready_s = 1'b0;
      d_ready_s  = 1'b0;
    end
  end

  assign acc_if_s = if_req_valid & if_ready_s;
  assign acc_d_s  = d_req_valid & d_ready_s;
  assign accept_s = acc_if_s | acc_d_s;

  // Request decode for the current arbitration winner; fetches are 4 bytes.
  assign rd_addr_s = d_ready_s ? d_addr : if_addr;
  assign size_s    = d_ready_s ? size_e'(d_size) : SZ_W;
  assign be_s      = be_of(size_s);
  // One extra bit so an access running past the top cannot wrap to a small value.
  assign end_s     = {1'b0, rd_addr_s} + (ADDR_W+1)'(bytes_of(size_s));
  assign err_s     = (end_s > MEM_BYTES);
  assign arr_we_s  = acc_d_s & d_we & ~err_s;

  tinker_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .raddr_i(rd_addr_s),
    .rdata_o(arr_rdata_s),
    .we_i   (arr_we_s),
    .waddr_i(d_addr),
    .wbe_i  (be_s),
    .wdata_i(d_wdata)
  );

  // Response payload at acceptance: zero-extended load/fetch bytes, zero for stores and errors.
  always_comb begin
    fresh_data_s = '0;
    for (int i = 0; i < 8; i++) begin
      if (be_s[i] && !err_s && !(d_ready_s && d_we)) begin
        fresh_data_s[8*i +: 8] = arr_rdata_s[8*i +: 8];
      end else begin
        fresh_data_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Transaction FSM next state, latency counter and grant history.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          last_d  = acc_d_s ? GNT_D : GNT_IF;
          cnt_d   = 16'd0;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // FSM state, counter and grant history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      last_q  <= GNT_IF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Capture the response payload at acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_data_q <= 64'd0;
      cap_err_q  <= 1'b0;
      cap_port_q <= GNT_IF;
    end else if (accept_s) begin
      cap_data_q <= fresh_data_s;
      cap_err_q  <= err_s;
      cap_port_q <= acc_d_s ? GNT_D : GNT_IF;
    end else begin
      cap_data_q <= cap_data_q;
      cap_err_q  <= cap_err_q;
      cap_port_q <= cap_port_q;
    end
  end

  // With LATENCY=1 RESP is entered at the acceptance edge, so bypass the capture regs.
  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);
  assign rsp_port_s   = (state_q == IDLE) ? (acc_d_s ? GNT_D : GNT_IF) : cap_port_q;
  assign rsp_data_s   = (state_q == IDLE) ? fresh_data_s : cap_data_q;
  assign rsp_err_s    = (state_q == IDLE) ? err_s : cap_err_q;

  // Registered response outputs; data/err hold until the next response on that port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rsp_valid_q <= 1'b0;
      if_rdata_q     <= '0;
      if_err_q       <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      d_rdata_q      <= '0;
      d_err_q        <= 1'b0;
    end else begin
      if_rsp_valid_q <= enter_resp_s && (rsp_port_s == GNT_IF);
      d_rsp_valid_q  <= enter_resp_s && (rsp_port_s == GNT_D);
      if (enter_resp_s && (rsp_port_s == GNT_IF)) begin
        if_rdata_q <= rsp_data_s[INSN_W-1:0];
        if_err_q   <= rsp_err_s;
      end
      if (enter_resp_s && (rsp_port_s == GNT_D)) begin
        d_rdata_q <= rsp_data_s[DATA_W-1:0];
        d_err_q   <= rsp_err_s;
      end
    end
  end

  assign if_req_ready = if_ready_s;
  assign d_req_ready  = d_ready_s;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign if_err       = if_err_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rdata      = d_rdata_q;
  assign d_err        = d_err_q;

endmodule
